vga_capture: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_sync_edge.sv | 39 +++
 rtl/vga_capture.sv | 154 +++++++++++++++
 tb/tb_vga_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Nominal 640x480 VGA raster constants and capture state encoding, shared by the
// generator and the capture block.
package vga_timing_pkg;

  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHFp     = 16;
  localparam int unsigned VgaHSync   = 96;
  localparam int unsigned VgaHBp     = 48;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVFp     = 10;
  localparam int unsigned VgaVSync   = 2;
  localparam int unsigned VgaVBp     = 33;
  localparam logic        VgaSyncPol = 1'b0;

  localparam int unsigned VgaHTotal = VgaHActive + VgaHFp + VgaHSync + VgaHBp;
  localparam int unsigned VgaVTotal = VgaVActive + VgaVFp + VgaVSync + VgaVBp;
  localparam int unsigned VgaHStart = VgaHSync + VgaHBp;
  localparam int unsigned VgaVStart = VgaVSync + VgaVBp;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } cap_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Input stage: registers syncs and RGB, and flags the leading hsync edge.
// Sync outputs are normalised to active-high regardless of SyncPol.
module vga_sync_edge #(
  parameter logic SyncPol = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  input  logic [11:0] rgb_i,
  output logic        vs_o,
  output logic        h_edge_o,
  output logic [11:0] rgb_o
);

  logic        hs1_q;
  logic        vs1_q;
  logic        hs2_q;
  logic [11:0] rgb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs1_q <= ~SyncPol;
      vs1_q <= ~SyncPol;
      hs2_q <= ~SyncPol;
      rgb_q <= '0;
    end else begin
      hs1_q <= h_sync_i;
      vs1_q <= v_sync_i;
      hs2_q <= hs1_q;
      rgb_q <= rgb_i;
    end
  end

  assign vs_o     = (vs1_q == SyncPol);
  assign h_edge_o = (hs1_q == SyncPol) && (hs2_q != SyncPol);
  assign rgb_o    = rgb_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers raster position from sync edges, verifies the timing and,
// once locked, streams visible pixels to a frame buffer at row*H_ACTIVE+col.
module vga_capture import vga_timing_pkg::*; #(
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_FP     = VgaHFp,
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BP     = VgaHBp,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_FP     = VgaVFp,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BP     = VgaVBp,
  parameter logic        SYNC_POL = VgaSyncPol
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  Red,
  input  logic [3:0]  Green,
  input  logic [3:0]  Blue,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned CntW    = 16;

  localparam logic [CntW-1:0] HMax     = CntW'(2 * H_TOTAL - 1);
  localparam logic [CntW-1:0] HLastCnt = CntW'(H_TOTAL - 1);
  localparam logic [CntW-1:0] VLastCnt = CntW'(V_TOTAL - 1);
  localparam logic [CntW-1:0] VMax     = '1;
  localparam logic [CntW-1:0] HLo      = CntW'(H_START);
  localparam logic [CntW-1:0] HHi      = CntW'(H_START + H_ACTIVE);
  localparam logic [CntW-1:0] VLo      = CntW'(V_START);
  localparam logic [CntW-1:0] VHi      = CntW'(V_START + V_ACTIVE);

  logic        vs;
  logic        h_edge;
  logic [11:0] rgb;

  vga_sync_edge #(
    .SyncPol (SYNC_POL)
  ) u_sync_edge (
    .clk_i    (clk),
    .rst_i    (rst),
    .h_sync_i (h_sync),
    .v_sync_i (v_sync),
    .rgb_i    ({Red, Green, Blue}),
    .vs_o     (vs),
    .h_edge_o (h_edge),
    .rgb_o    (rgb)
  );

  cap_state_e      state_q, state_d;
  logic [CntW-1:0] h_cnt_q, h_cnt_d;
  logic [CntW-1:0] v_cnt_q, v_cnt_d;
  logic            vs_lat_q, vs_lat_d;
  logic [31:0]     addr_q, addr_d;
  logic            wr_en_q, frame_start_q, timing_err_q, locked_q;
  logic [31:0]     wr_addr_q;
  logic [15:0]     wr_data_q;

  logic frame_ev, line_bad, frame_bad, h_sat, err, wr, in_win;

  always_comb begin
    h_sat     = !h_edge && (h_cnt_q == HMax - CntW'(1));
    frame_ev  = h_edge && vs && !vs_lat_q;
    line_bad  = h_edge && (h_cnt_q != HLastCnt);
    frame_bad = frame_ev && (v_cnt_q != VLastCnt);
    vs_lat_d  = h_edge ? vs : vs_lat_q;

    if (h_edge)                h_cnt_d = '0;
    else if (h_cnt_q == HMax)  h_cnt_d = HMax;
    else                       h_cnt_d = h_cnt_q + CntW'(1);

    if (frame_ev)                      v_cnt_d = '0;
    else if (h_edge && v_cnt_q != VMax) v_cnt_d = v_cnt_q + CntW'(1);
    else                               v_cnt_d = v_cnt_q;

    state_d = state_q;
    err     = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (frame_ev) state_d = StMeasure;
      end
      StMeasure: begin
        if (line_bad || h_sat || frame_bad) begin
          state_d = StSearch;
          err     = 1'b1;
        end else if (frame_ev) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (line_bad || h_sat || frame_bad) begin
          state_d = StSearch;
          err     = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase

    // Window uses this sample's position, i.e. the next-state counters.
    in_win = (h_cnt_d >= HLo) && (h_cnt_d < HHi) && (v_cnt_d >= VLo) && (v_cnt_d < VHi);
    wr     = (state_d == StLocked) && in_win;

    if (frame_ev) addr_d = '0;
    else if (wr)  addr_d = addr_q + 32'd1;
    else          addr_d = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSearch;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vs_lat_q      <= 1'b0;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_lat_q      <= vs_lat_d;
      addr_q        <= addr_d;
      wr_en_q       <= wr;
      wr_addr_q     <= wr ? addr_q : '0;
      wr_data_q     <= wr ? {4'b0000, rgb} : '0;
      frame_start_q <= frame_ev;
      timing_err_q  <= err;
      locked_q      <= (state_d == StLocked);
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = frame_start_q;
  assign timing_err  = timing_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a shrunken raster: a frame-level lock model predicts
// every write, error pulse and frame start from the stream it generates.
module tb_vga_capture;

  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT  = HA + HF + HS + HB;
  localparam int unsigned VT  = VA + VF + VS + VB;
  localparam int unsigned HST = HS + HB;
  localparam int unsigned VST = VS + VB;
  localparam logic        POL = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_sync, v_sync;
  logic [3:0]  red, green, blue;
  logic        wr_en, frame_start, locked, timing_err;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;

  vga_capture #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .Red         (red),
    .Green       (green),
    .Blue        (blue),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_err  (timing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t wr_log[$];
  int  cyc = 0;
  int  drv_cyc = 0;
  int  n_cmp = 0, n_bad = 0;
  int  got_err = 0, got_fs = 0;
  int  exp_err = 0, exp_fs = 0;
  int  stage = 0, last_len = 0, line_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t w, e;
    if (wr_en) begin
      w.addr = wr_addr; w.data = wr_data; w.cyc = cyc;
      wr_log.push_back(w);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", wr_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", {16'h0, wr_data}, {16'h0, e.data});
        check("wr_latency", cyc, e.cyc);
      end
    end
    if (timing_err) begin
      got_err++;
      check("err_with_locked", {31'h0, locked}, 32'h0);
    end
    if (frame_start) got_fs++;
  end

  task automatic drive(input logic r, input bit hs_a, input bit vs_a, input logic [11:0] pix);
    @(posedge clk);
    #1;
    rst    = r;
    h_sync = hs_a ? POL : ~POL;
    v_sync = vs_a ? POL : ~POL;
    {red, green, blue} = pix;
    drv_cyc = cyc;
  endtask

  // Lock model: 0 = searching, 1 = measuring one frame, 2 = locked.
  task automatic model_line_start(input bit first_line);
    bit line_bad, frame_bad;
    line_bad  = (last_len != HT);
    frame_bad = (line_count != VT);
    if (first_line) begin
      exp_fs++;
      if (stage == 0) stage = 1;
      else if (line_bad || frame_bad) begin stage = 0; exp_err++; end
      else stage = 2;
      line_count = 1;
    end else begin
      if (stage != 0 && line_bad) begin stage = 0; exp_err++; end
      line_count++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, {31'h0, wr_en}, 32'h0);
    check({tag, "_wr_addr"}, wr_addr, 32'h0);
    check({tag, "_wr_data"}, {16'h0, wr_data}, 32'h0);
    check({tag, "_frame_start"}, {31'h0, frame_start}, 32'h0);
    check({tag, "_timing_err"}, {31'h0, timing_err}, 32'h0);
    check({tag, "_locked"}, {31'h0, locked}, 32'h0);
  endtask

  task automatic send_frame(input string tag, input int nlines, input int short_line,
                            input int rst_line, input bit addr_mode);
    for (int l = 0; l < nlines; l++) begin
      int len;
      if (l == rst_line) begin
        drive(1'b1, 1'b0, 1'b0, 12'h0);
        stage = 0;
        drive(1'b0, 1'b0, 1'b0, 12'h0);
        @(negedge clk);
        #1;
        check_idle_outputs({tag, "_rst"});
        continue;
      end
      len = (l == short_line) ? HT - 1 : HT;
      for (int x = 0; x < len; x++) begin
        bit          act;
        int          a;
        logic [11:0] pix;
        wr_t         e;
        if (x == 0) model_line_start(l == 0);
        act = (x >= HST) && (x < HST + HA) && (l >= VST) && (l < VST + VA);
        a   = (l - VST) * HA + (x - HST);
        pix = 12'h0;
        if (act) pix = addr_mode ? 12'(a) : 12'($urandom);
        drive(1'b0, x < HS, l < VS, pix);
        if (act && stage == 2) begin
          e.addr = 32'(a); e.data = {4'h0, pix}; e.cyc = drv_cyc + 2;
          exp_q.push_back(e);
        end
      end
      last_len = len;
    end
    @(negedge clk);
    #1;
    check({tag, "_frame_starts"}, got_fs, exp_fs);
    check({tag, "_timing_errs"}, got_err, exp_err);
    check({tag, "_locked"}, {31'h0, locked}, {31'h0, stage == 2});
    check({tag, "_writes_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int mark, s, r;
    rst = 1'b1;
    h_sync = ~POL; v_sync = ~POL;
    red = 4'h0; green = 4'h0; blue = 4'h0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    repeat (60) drive(1'b0, 1'b0, 1'b0, 12'h0);
    @(negedge clk);
    #1;
    check("idle_frame_starts", got_fs, 0);
    check("idle_timing_errs", got_err, 0);
    check("idle_locked", {31'h0, locked}, 32'h0);
    check("idle_writes", wr_log.size(), 0);

    send_frame("measure", VT, -1, -1, 1'b1);
    mark = wr_log.size();
    send_frame("lock", VT, -1, -1, 1'b1);
    check("lock_count", wr_log.size() - mark, HA * VA);
    check("lock_first_addr", wr_log[mark].addr, 32'h0);
    check("lock_first_data", {16'h0, wr_log[mark].data}, 32'h0);
    check("lock_last_addr", wr_log[wr_log.size()-1].addr, HA * VA - 1);
    check("lock_last_data", {16'h0, wr_log[wr_log.size()-1].data}, (HA * VA - 1) & 32'hFFF);

    send_frame("random", VT, -1, -1, 1'b0);

    s = VST + $urandom_range(VA - 2);
    mark = wr_log.size();
    send_frame("short_line", VT, s, -1, 1'b0);
    check("short_line_count", wr_log.size() - mark, (s - VST + 1) * HA);
    send_frame("relock_a", VT, -1, -1, 1'b0);
    mark = wr_log.size();
    send_frame("relock_b", VT, -1, -1, 1'b0);
    check("relock_count", wr_log.size() - mark, HA * VA);

    send_frame("short_frame", VT - 1, -1, -1, 1'b0);
    send_frame("bad_frame_event", VT, -1, -1, 1'b0);
    send_frame("relock_c", VT, -1, -1, 1'b0);
    send_frame("relock_d", VT, -1, -1, 1'b0);

    r = VST + $urandom_range(VA - 1);
    send_frame("reset_mid", VT, -1, r, 1'b1);
    send_frame("post_rst_a", VT, -1, -1, 1'b1);
    mark = wr_log.size();
    send_frame("post_rst_b", VT, -1, -1, 1'b1);
    check("post_rst_count", wr_log.size() - mark, HA * VA);
    if (wr_log.size() > mark) check("post_rst_first_addr", wr_log[mark].addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
